// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle IF/ID/EXE/MEM/WB control FSM
// State and latched opcode are registered; outputs decode from them (PCSrc also from zero in beq EXE).
module multicycle_control_unit #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               ALUSrcB,
  output logic               ALUM2Reg,
  output logic               RegWre,
  output logic               RegOut,
  output logic               ExtSel,
  output logic               DataMemRW,
  output logic               InsMemRW,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [5:0] OPC_ADD  = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b000001;
  localparam logic [5:0] OPC_SUB  = 6'b000010;
  localparam logic [5:0] OPC_ORI  = 6'b010000;
  localparam logic [5:0] OPC_AND  = 6'b010001;
  localparam logic [5:0] OPC_OR   = 6'b010010;
  localparam logic [5:0] OPC_MOVE = 6'b100000;
  localparam logic [5:0] OPC_SW   = 6'b100110;
  localparam logic [5:0] OPC_LW   = 6'b100111;
  localparam logic [5:0] OPC_BEQ  = 6'b110000;
  localparam logic [5:0] OPC_J    = 6'b111000;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  localparam int MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT} state_t;

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic [MW-1:0]   mem_cnt;

  logic [5:0] op_lo;
  logic       hi_zero;
  logic is_add, is_addi, is_sub, is_ori, is_and, is_or, is_move;
  logic is_sw, is_lw, is_beq, is_j, is_halt, is_legal, is_mem, mem_last;

  // Wider opcode fields are only legal when the bits above the 6-bit code are clear.
  assign op_lo   = op_q[5:0];
  assign hi_zero = ((op_q >> 6) == '0);

  assign is_add   = hi_zero && (op_lo == OPC_ADD);
  assign is_addi  = hi_zero && (op_lo == OPC_ADDI);
  assign is_sub   = hi_zero && (op_lo == OPC_SUB);
  assign is_ori   = hi_zero && (op_lo == OPC_ORI);
  assign is_and   = hi_zero && (op_lo == OPC_AND);
  assign is_or    = hi_zero && (op_lo == OPC_OR);
  assign is_move  = hi_zero && (op_lo == OPC_MOVE);
  assign is_sw    = hi_zero && (op_lo == OPC_SW);
  assign is_lw    = hi_zero && (op_lo == OPC_LW);
  assign is_beq   = hi_zero && (op_lo == OPC_BEQ);
  assign is_j     = hi_zero && (op_lo == OPC_J);
  assign is_halt  = hi_zero && (op_lo == OPC_HALT);
  assign is_mem   = is_sw || is_lw;
  assign is_legal = is_add || is_addi || is_sub || is_ori || is_and || is_or || is_move ||
                    is_sw || is_lw || is_beq || is_j || is_halt;
  assign mem_last = (mem_cnt == MW'(MEM_LAT - 1));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= S_IF;
      op_q        <= '0;
      mem_cnt     <= '0;
      instr_count <= '0;
    end else begin
      if (PCWre) instr_count <= instr_count + CNT_W'(1);
      case (state)
        S_IF: begin
          op_q  <= op;
          state <= S_ID;
        end
        S_ID: begin
          if (is_j)           state <= S_IF;
          else if (is_halt)   state <= S_HALT;
          else if (!is_legal) state <= S_IF;
          else                state <= S_EXE;
        end
        S_EXE: begin
          if (is_beq) begin
            state <= S_IF;
          end else if (is_mem) begin
            state   <= S_MEM;
            mem_cnt <= '0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_last) state <= is_sw ? S_IF : S_WB;
          else          mem_cnt <= mem_cnt + MW'(1);
        end
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    RegWre    = 1'b0;
    RegOut    = 1'b0;
    ExtSel    = 1'b0;
    DataMemRW = 1'b0;
    InsMemRW  = 1'b0;
    ALUOp     = '0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (!Reset) begin
      if (state == S_ID || state == S_EXE || state == S_MEM || state == S_WB) begin
        ALUSrcB  = is_addi || is_ori || is_lw || is_sw;
        ExtSel   = is_addi || is_lw || is_sw || is_beq;
        RegOut   = is_add || is_sub || is_and || is_or || is_move;
        ALUM2Reg = is_lw;
        if (is_sub || is_beq)     ALUOp = ALUOP_W'(3'b001);
        else if (is_ori || is_or) ALUOp = ALUOP_W'(3'b011);
        else if (is_and)          ALUOp = ALUOP_W'(3'b100);
        else                      ALUOp = '0;
      end
      case (state)
        S_IF: begin
          IRWre    = 1'b1;
          InsMemRW = 1'b1;
        end
        S_ID: begin
          if (is_j) begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
          end else if (!is_legal) begin
            PCWre   = 1'b1;
            illegal = 1'b1;
          end
        end
        S_EXE: begin
          if (is_beq) begin
            PCWre = 1'b1;
            PCSrc = {1'b0, zero};
          end
        end
        S_MEM: begin
          DataMemRW = is_sw;
          PCWre     = is_sw && mem_last;
        end
        S_WB: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed vector bench for multicycle_control_unit
// Vectors are per-cycle {op, zero, expected control word, expected instr_count}.
module tb_multicycle_control_unit;

  logic       CLK;
  logic       Reset;
  logic [5:0] op;
  logic       zero;
  logic       PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, RegOut, ExtSel, DataMemRW, InsMemRW;
  logic       halted, illegal;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] instr_count;

  multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .MEM_LAT(3), .CNT_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
    .RegWre(RegWre), .RegOut(RegOut), .ExtSel(ExtSel), .DataMemRW(DataMemRW),
    .InsMemRW(InsMemRW), .ALUOp(ALUOp), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Control word bit positions
  localparam logic [15:0] IRW = 16'h8000, IMR = 16'h4000, PCW = 16'h2000;
  localparam logic [15:0] PCS_J = 16'h1000, PCS_BR = 16'h0800, SRCB = 16'h0400;
  localparam logic [15:0] M2R = 16'h0200, RW = 16'h0100, RO = 16'h0080, EXT = 16'h0040;
  localparam logic [15:0] DM = 16'h0020, AOP4 = 16'h0010, AOP3 = 16'h000C, AOP1 = 16'h0004;
  localparam logic [15:0] HLT = 16'h0002, ILL = 16'h0001;
  localparam logic [15:0] FETCH = IRW | IMR;
  localparam logic [5:0]  X = 6'h3F;

  wire [15:0] got = {IRWre, InsMemRW, PCWre, PCSrc, ALUSrcB, ALUM2Reg, RegWre, RegOut,
                     ExtSel, DataMemRW, ALUOp, halted, illegal};

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic [15:0] exp;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rw_seen;
  logic watch_rw = 1'b0;

  always @(posedge RegWre) if (watch_rw) rw_seen = 1'b1;

  task automatic v(input logic [5:0] o, input logic z, input logic [15:0] e, input logic [3:0] c);
    vec_t t;
    t.op = o; t.zero = z; t.exp = e; t.cnt = c;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, actual, expected);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // add, beq taken/not taken, sw, lw, ori, j, illegal, and, sub, or, move, addi, halt
    v(6'h00,0,FETCH,0); v(X,0,RO,0); v(X,0,RO,0); v(X,0,RO|RW|PCW,0);
    v(6'h30,1,FETCH,1); v(X,1,EXT|AOP1,1); v(X,1,EXT|AOP1|PCW|PCS_BR,1);
    v(6'h30,0,FETCH,2); v(X,0,EXT|AOP1,2); v(X,0,EXT|AOP1|PCW,2);
    v(6'h26,0,FETCH,3); v(X,0,SRCB|EXT,3); v(X,0,SRCB|EXT,3);
    v(X,0,SRCB|EXT|DM,3); v(X,0,SRCB|EXT|DM,3); v(X,0,SRCB|EXT|DM|PCW,3);
    v(6'h27,0,FETCH,4);
    for (int k = 0; k < 5; k++) v(X,0,SRCB|EXT|M2R,4);
    v(X,0,SRCB|EXT|M2R|RW|PCW,4);
    v(6'h10,0,FETCH,5); v(X,0,SRCB|AOP3,5); v(X,0,SRCB|AOP3,5); v(X,0,SRCB|AOP3|RW|PCW,5);
    v(6'h38,0,FETCH,6); v(X,0,PCW|PCS_J,6);
    v(6'h2A,0,FETCH,7); v(X,0,PCW|ILL,7);
    v(6'h11,0,FETCH,8); v(X,0,RO|AOP4,8); v(X,0,RO|AOP4,8); v(X,0,RO|AOP4|RW|PCW,8);
    v(6'h02,0,FETCH,9); v(X,0,RO|AOP1,9); v(X,0,RO|AOP1,9); v(X,0,RO|AOP1|RW|PCW,9);
    v(6'h12,0,FETCH,10); v(X,0,RO|AOP3,10); v(X,0,RO|AOP3,10); v(X,0,RO|AOP3|RW|PCW,10);
    v(6'h20,0,FETCH,11); v(X,0,RO,11); v(X,0,RO,11); v(X,0,RO|RW|PCW,11);
    v(6'h01,0,FETCH,12); v(X,0,SRCB|EXT,12); v(X,0,SRCB|EXT,12); v(X,0,SRCB|EXT|RW|PCW,12);
    v(6'h3F,0,FETCH,13); v(6'h00,0,16'h0,13);
    v(6'h00,0,HLT,13); v(6'h38,0,HLT,13); v(6'h2A,0,HLT,13); v(6'h26,1,HLT,13);

    Reset = 1'b1; op = 6'h00; zero = 1'b0;
    #2;
    chk("reset_outputs", 32'(got), 32'h0);
    chk("reset_count", 32'(instr_count), 32'h0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    foreach (tbl[i]) begin
      op = tbl[i].op; zero = tbl[i].zero;
      #2;
      chk($sformatf("vec%0d_ctl", i), 32'(got), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(instr_count), 32'(tbl[i].cnt));
      @(negedge CLK);
    end

    // Reset releases HALT
    Reset = 1'b1;
    #2;
    chk("halt_reset_outputs", 32'(got), 32'h0);
    chk("halt_reset_count", 32'(instr_count), 32'h0);
    @(negedge CLK);
    Reset = 1'b0;

    // 17 jumps on a 4-bit counter wrap to 1
    for (int k = 0; k < 17; k++) begin
      op = 6'h38;
      #2;
      chk($sformatf("j%0d_fetch", k), 32'(got), 32'(FETCH));
      @(negedge CLK);
      op = X;
      #2;
      chk($sformatf("j%0d_id", k), 32'(got), 32'(PCW | PCS_J));
      @(negedge CLK);
    end
    #2;
    chk("count_wrap", 32'(instr_count), 32'h1);

    // Reset asserted during EXE of addi aborts without a register write
    rw_seen = 1'b0; watch_rw = 1'b1;
    op = 6'h01;
    @(negedge CLK);
    op = X;
    @(negedge CLK);
    #2;
    chk("addi_exe", 32'(got), 32'(SRCB | EXT));
    #1 Reset = 1'b1;
    #1;
    chk("abort_outputs", 32'(got), 32'h0);
    chk("abort_count", 32'(instr_count), 32'h0);
    repeat (2) @(negedge CLK);
    #2;
    chk("abort_held", 32'(got), 32'h0);
    chk("abort_no_regwre", 32'(rw_seen), 32'h0);
    @(negedge CLK);
    Reset = 1'b0; op = 6'h00;
    #2;
    chk("post_abort_fetch", 32'(got), 32'(FETCH));
    watch_rw = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
